// File: rtl/bus_pkg.sv
// Shared encodings for the processor bus: destination/source codes and
// increment-request bit positions.
package bus_pkg;

  typedef enum logic [3:0] {
    WR_NONE = 4'd0,
    WR_R    = 4'd1,
    WR_DR   = 4'd2,
    WR_TR   = 4'd3,
    WR_PC   = 4'd4,
    WR_AC   = 4'd5,
    WR_R1   = 4'd6,
    WR_R2   = 4'd7,
    WR_RI   = 4'd8,
    WR_RJ   = 4'd9,
    WR_RK   = 4'd10,
    WR_DM   = 4'd11,
    WR_AR   = 4'd12
  } wr_code_e;

  localparam int unsigned INC_PC = 0;
  localparam int unsigned INC_AC = 1;
  localparam int unsigned INC_RI = 2;
  localparam int unsigned INC_RJ = 3;
  localparam int unsigned INC_RK = 4;

endpackage

// File: rtl/bus_write_bank_if.sv
// Write-side bus bundle: control/bus inputs from the sequencer, register
// contents and data-memory strobes back out.
interface bus_write_bank_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 8
);
  logic [DW-1:0] bus_in;
  logic [3:0]    write_en;
  logic [4:0]    inc_en;
  logic          clr_ac;
  logic [RW-1:0] r, dr, pc, ar, r1, r2, ri, rj, rk;
  logic [DW-1:0] tr, ac;
  logic          z;
  logic          dm_we;
  logic [RW-1:0] dm_addr;
  logic [RW-1:0] dm_wdata;
  logic          err;

  modport master (
    output bus_in, write_en, inc_en, clr_ac,
    input  r, dr, pc, ar, r1, r2, ri, rj, rk, tr, ac, z,
    input  dm_we, dm_addr, dm_wdata, err
  );

  modport slave (
    input  bus_in, write_en, inc_en, clr_ac,
    output r, dr, pc, ar, r1, r2, ri, rj, rk, tr, ac, z,
    output dm_we, dm_addr, dm_wdata, err
  );
endinterface

// File: rtl/bus_inc_reg.sv
// Width-parameterised register with load, clear and increment; priority is
// load > clear > increment, increment wraps modulo 2**W.
module bus_inc_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
    else if (clr)  q <= '0;
    else if (inc)  q <= q + W'(1);
  end

endmodule

// File: rtl/bus_write_bank.sv
// Bus write bank: decodes write_en into a single destination load, applies
// per-register increments/AC clear, and issues one-cycle data-memory strobes.
module bus_write_bank
  import bus_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 8
) (
  input  logic           clk,
  input  logic           rst,
  bus_write_bank_if.slave bif
);

  wr_code_e      code;
  logic          ld_r, ld_dr, ld_tr, ld_pc, ld_ac, ld_r1, ld_r2;
  logic          ld_ri, ld_rj, ld_rk, ld_dm, ld_ar, illegal;
  logic [RW-1:0] bus_lo;

  logic [RW-1:0] r_q, dr_q, ar_q, r1_q, r2_q;
  logic [RW-1:0] pc_q, ri_q, rj_q, rk_q;
  logic [DW-1:0] tr_q, ac_q;
  logic          dm_we_q, err_q;
  logic [RW-1:0] dm_wdata_q;

  assign code   = wr_code_e'(bif.write_en);
  assign bus_lo = bif.bus_in[RW-1:0];

  always_comb begin
    ld_r    = 1'b0;
    ld_dr   = 1'b0;
    ld_tr   = 1'b0;
    ld_pc   = 1'b0;
    ld_ac   = 1'b0;
    ld_r1   = 1'b0;
    ld_r2   = 1'b0;
    ld_ri   = 1'b0;
    ld_rj   = 1'b0;
    ld_rk   = 1'b0;
    ld_dm   = 1'b0;
    ld_ar   = 1'b0;
    illegal = 1'b0;
    case (code)
      WR_NONE: ;
      WR_R:    ld_r  = 1'b1;
      WR_DR:   ld_dr = 1'b1;
      WR_TR:   ld_tr = 1'b1;
      WR_PC:   ld_pc = 1'b1;
      WR_AC:   ld_ac = 1'b1;
      WR_R1:   ld_r1 = 1'b1;
      WR_R2:   ld_r2 = 1'b1;
      WR_RI:   ld_ri = 1'b1;
      WR_RJ:   ld_rj = 1'b1;
      WR_RK:   ld_rk = 1'b1;
      WR_DM:   ld_dm = 1'b1;
      WR_AR:   ld_ar = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= '0;
      dr_q <= '0;
      tr_q <= '0;
      ar_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
    end else begin
      if (ld_r)  r_q  <= bus_lo;
      if (ld_dr) dr_q <= bus_lo;
      if (ld_tr) tr_q <= bif.bus_in;
      if (ld_ar) ar_q <= bus_lo;
      if (ld_r1) r1_q <= bus_lo;
      if (ld_r2) r2_q <= bus_lo;
    end
  end

  // dm_wdata holds between strobes; dm_we and err are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_we_q    <= 1'b0;
      dm_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      dm_we_q <= ld_dm;
      err_q   <= illegal;
      if (ld_dm) dm_wdata_q <= bus_lo;
    end
  end

  bus_inc_reg #(.W(RW)) u_pc (
    .clk(clk), .rst(rst), .load(ld_pc), .clr(1'b0),
    .inc(bif.inc_en[INC_PC]), .d(bus_lo), .q(pc_q)
  );

  bus_inc_reg #(.W(DW)) u_ac (
    .clk(clk), .rst(rst), .load(ld_ac), .clr(bif.clr_ac),
    .inc(bif.inc_en[INC_AC]), .d(bif.bus_in), .q(ac_q)
  );

  bus_inc_reg #(.W(RW)) u_ri (
    .clk(clk), .rst(rst), .load(ld_ri), .clr(1'b0),
    .inc(bif.inc_en[INC_RI]), .d(bus_lo), .q(ri_q)
  );

  bus_inc_reg #(.W(RW)) u_rj (
    .clk(clk), .rst(rst), .load(ld_rj), .clr(1'b0),
    .inc(bif.inc_en[INC_RJ]), .d(bus_lo), .q(rj_q)
  );

  bus_inc_reg #(.W(RW)) u_rk (
    .clk(clk), .rst(rst), .load(ld_rk), .clr(1'b0),
    .inc(bif.inc_en[INC_RK]), .d(bus_lo), .q(rk_q)
  );

  assign bif.r        = r_q;
  assign bif.dr       = dr_q;
  assign bif.pc       = pc_q;
  assign bif.ar       = ar_q;
  assign bif.r1       = r1_q;
  assign bif.r2       = r2_q;
  assign bif.ri       = ri_q;
  assign bif.rj       = rj_q;
  assign bif.rk       = rk_q;
  assign bif.tr       = tr_q;
  assign bif.ac       = ac_q;
  assign bif.z        = (ac_q == '0);
  assign bif.dm_we    = dm_we_q;
  assign bif.dm_addr  = ar_q;
  assign bif.dm_wdata = dm_wdata_q;
  assign bif.err      = err_q;

endmodule

// File: tb/tb_bus_write_bank.sv
// Directed bench for bus_write_bank: hand-computed register, flag and
// data-memory strobe expectations checked with immediate assertions.
module tb_bus_write_bank;

  logic clk;
  logic rst;
  int   npass;
  int   ntot;

  bus_write_bank_if #(.DW(16), .RW(8)) bif ();

  bus_write_bank #(.DW(16), .RW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] we, input logic [15:0] bus,
                       input logic [4:0] inc, input logic clr);
    bif.write_en = we;
    bif.bus_in   = bus;
    bif.inc_en   = inc;
    bif.clr_ac   = clr;
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    rst   = 1'b1;
    drive(4'd0, 16'h0000, 5'b00000, 1'b0);
    #2;
    check("rst_ac", bif.ac, 16'h0000);
    check("rst_z", 16'(bif.z), 16'h0001);
    check("rst_dm_we", 16'(bif.dm_we), 16'h0000);
    check("rst_err", 16'(bif.err), 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // TR, AC, R loads from one bus value
    drive(4'd3, 16'hABCD, 5'b00000, 1'b0);
    step();
    check("tr_load", bif.tr, 16'hABCD);
    check("z_before_ac", 16'(bif.z), 16'h0001);
    drive(4'd5, 16'hABCD, 5'b00000, 1'b0);
    step();
    check("ac_load", bif.ac, 16'hABCD);
    check("z_after_ac", 16'(bif.z), 16'h0000);
    drive(4'd1, 16'hABCD, 5'b00000, 1'b0);
    step();
    check("r_low_byte", 16'(bif.r), 16'h00CD);

    // PC and AC wrap-around
    drive(4'd4, 16'h00FF, 5'b00000, 1'b0);
    step();
    check("pc_load", 16'(bif.pc), 16'h00FF);
    drive(4'd0, 16'h0000, 5'b00001, 1'b0);
    step();
    check("pc_wrap", 16'(bif.pc), 16'h0000);
    drive(4'd5, 16'hFFFF, 5'b00000, 1'b0);
    step();
    check("ac_ffff", bif.ac, 16'hFFFF);
    drive(4'd0, 16'h0000, 5'b00010, 1'b0);
    step();
    check("ac_wrap", bif.ac, 16'h0000);
    check("ac_wrap_z", 16'(bif.z), 16'h0001);

    // Priority: write > clear > increment
    drive(4'd5, 16'h0005, 5'b00000, 1'b0);
    step();
    check("ac_5", bif.ac, 16'h0005);
    drive(4'd5, 16'h0007, 5'b00010, 1'b1);
    step();
    check("prio_write", bif.ac, 16'h0007);
    drive(4'd0, 16'h0000, 5'b00010, 1'b1);
    step();
    check("prio_clear", bif.ac, 16'h0000);

    // AR then back-to-back DM strobes
    drive(4'd12, 16'h0040, 5'b00000, 1'b0);
    step();
    check("ar_load", 16'(bif.ar), 16'h0040);
    check("dm_we_idle", 16'(bif.dm_we), 16'h0000);
    drive(4'd11, 16'h0099, 5'b00000, 1'b0);
    step();
    check("dm_we_1", 16'(bif.dm_we), 16'h0001);
    check("dm_addr", 16'(bif.dm_addr), 16'h0040);
    check("dm_wdata", 16'(bif.dm_wdata), 16'h0099);
    step();
    check("dm_we_2", 16'(bif.dm_we), 16'h0001);
    drive(4'd0, 16'h0000, 5'b00000, 1'b0);
    step();
    check("dm_we_3", 16'(bif.dm_we), 16'h0000);

    // Illegal code with a concurrent increment
    drive(4'd8, 16'h0003, 5'b00000, 1'b0);
    step();
    check("ri_load", 16'(bif.ri), 16'h0003);
    drive(4'd14, 16'h5A5A, 5'b00100, 1'b0);
    step();
    check("err_pulse", 16'(bif.err), 16'h0001);
    check("ri_inc", 16'(bif.ri), 16'h0004);
    check("ill_r_hold", 16'(bif.r), 16'h00CD);
    check("ill_tr_hold", bif.tr, 16'hABCD);
    check("ill_ac_hold", bif.ac, 16'h0000);
    check("ill_ar_hold", 16'(bif.ar), 16'h0040);
    check("ill_pc_hold", 16'(bif.pc), 16'h0000);
    drive(4'd0, 16'h0000, 5'b00000, 1'b0);
    step();
    check("err_clear", 16'(bif.err), 16'h0000);

    // Write DR while incrementing RI/RJ/RK in parallel
    drive(4'd2, 16'h1255, 5'b11100, 1'b0);
    step();
    check("dr_load", 16'(bif.dr), 16'h0055);
    check("ri_par", 16'(bif.ri), 16'h0005);
    check("rj_par", 16'(bif.rj), 16'h0001);
    check("rk_par", 16'(bif.rk), 16'h0001);

    // Asynchronous reset mid-operation with AC loaded and a strobe active
    drive(4'd5, 16'h1234, 5'b00000, 1'b0);
    step();
    drive(4'd11, 16'h0077, 5'b00000, 1'b0);
    step();
    check("pre_rst_ac", bif.ac, 16'h1234);
    check("pre_rst_dm_we", 16'(bif.dm_we), 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ac", bif.ac, 16'h0000);
    check("mid_rst_z", 16'(bif.z), 16'h0001);
    check("mid_rst_dm_we", 16'(bif.dm_we), 16'h0000);
    check("mid_rst_wdata", 16'(bif.dm_wdata), 16'h0000);
    check("mid_rst_tr", bif.tr, 16'h0000);
    check("mid_rst_addr", 16'(bif.dm_addr), 16'h0000);
    drive(4'd0, 16'h0000, 5'b00000, 1'b0);
    #1;
    rst = 1'b0;
    step();
    check("post_rst_dm_we", 16'(bif.dm_we), 16'h0000);
    check("post_rst_ac", bif.ac, 16'h0000);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
